// File: rtl/rn_inject_arb.sv
// rn_inject_arb: credit-based AW/W/AR flit injection arbiter for a request node.
// Optional feature macro: RN_INJ_AR_PRIO_EN (AR strict priority when unlocked).
module rn_inject_arb #(
    parameter int PAYLOAD_W = 82,
    parameter int TGT_W     = 2,
    parameter int CREDITS   = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       aw_valid,
    output logic                       aw_ready,
    input  logic [PAYLOAD_W-1:0]       aw_payload,
    input  logic [TGT_W-1:0]           aw_tgtid,

    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic                       w_head,
    input  logic                       w_tail,
    input  logic [PAYLOAD_W-1:0]       w_payload,
    input  logic [TGT_W-1:0]           w_tgtid,

    input  logic                       ar_valid,
    output logic                       ar_ready,
    input  logic [PAYLOAD_W-1:0]       ar_payload,
    input  logic [TGT_W-1:0]           ar_tgtid,

    output logic                       noc_valid,
    output logic [PAYLOAD_W+TGT_W+3:0] noc_flit,

    input  logic                       credit_in,
    output logic [3:0]                 credit_cnt,
    output logic                       credit_err
);

    localparam int         FLIT_W   = PAYLOAD_W + TGT_W + 4;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    typedef enum logic [1:0] {
        CH_AW = 2'd0,
        CH_W  = 2'd1,
        CH_AR = 2'd2
    } chan_e;

    typedef enum logic {
        ST_OPEN,
        ST_LOCK
    } state_e;

`ifdef RN_INJ_AR_PRIO_EN
    // AR sits outside the rotation, so W hands the turn back to AW.
    localparam chan_e PTR_AFTER_W = CH_AW;
`else
    localparam chan_e PTR_AFTER_W = CH_AR;
`endif

    state_e              state_q, state_d;
    chan_e               ptr_q, ptr_d;
    logic [3:0]          cred_q, cred_d;
    logic                err_q, err_d;
    logic                nvalid_q, nvalid_d;
    logic [FLIT_W-1:0]   flit_q, flit_d;

    logic                can_grant;
    logic                gnt_aw, gnt_w, gnt_ar;
    logic                any_gnt;
    logic [FLIT_W-1:0]   sel_flit;

    // Grant selection: lock first, then round robin (or AR priority).
    always_comb begin
        gnt_aw    = 1'b0;
        gnt_w     = 1'b0;
        gnt_ar    = 1'b0;
        can_grant = !rst && (cred_q != 4'd0);
        if (can_grant) begin
            if (state_q == ST_LOCK) begin
                gnt_w = w_valid;
            end else begin
`ifdef RN_INJ_AR_PRIO_EN
                if (ar_valid) begin
                    gnt_ar = 1'b1;
                end else if (ptr_q == CH_W) begin
                    if (w_valid)       gnt_w  = 1'b1;
                    else if (aw_valid) gnt_aw = 1'b1;
                end else begin
                    if (aw_valid)      gnt_aw = 1'b1;
                    else if (w_valid)  gnt_w  = 1'b1;
                end
`else
                unique case (ptr_q)
                    CH_W: begin
                        if (w_valid)       gnt_w  = 1'b1;
                        else if (ar_valid) gnt_ar = 1'b1;
                        else if (aw_valid) gnt_aw = 1'b1;
                    end
                    CH_AR: begin
                        if (ar_valid)      gnt_ar = 1'b1;
                        else if (aw_valid) gnt_aw = 1'b1;
                        else if (w_valid)  gnt_w  = 1'b1;
                    end
                    default: begin
                        if (aw_valid)      gnt_aw = 1'b1;
                        else if (w_valid)  gnt_w  = 1'b1;
                        else if (ar_valid) gnt_ar = 1'b1;
                    end
                endcase
`endif
            end
        end
    end

    assign aw_ready = gnt_aw;
    assign w_ready  = gnt_w;
    assign ar_ready = gnt_ar;
    assign any_gnt  = gnt_aw | gnt_w | gnt_ar;

    // Lock state and RR pointer next-state; the pointer never moves mid-burst.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (gnt_w) begin
            if (w_tail) begin
                state_d = ST_OPEN;
                ptr_d   = PTR_AFTER_W;
            end else if (state_q == ST_OPEN) begin
                ptr_d = PTR_AFTER_W;
                if (w_head) begin
                    state_d = ST_LOCK;
                end
            end
        end else if (gnt_aw) begin
            ptr_d = CH_W;
        end else if (gnt_ar) begin
`ifdef RN_INJ_AR_PRIO_EN
            ptr_d = ptr_q;
`else
            ptr_d = CH_AW;
`endif
        end
    end

    // Credit counter: grant and return in one cycle cancel out.
    always_comb begin
        cred_d = cred_q;
        err_d  = err_q;
        if (any_gnt && !credit_in) begin
            cred_d = cred_q - 4'd1;
        end else if (!any_gnt && credit_in) begin
            if (cred_q >= CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                cred_d = cred_q + 4'd1;
            end
        end
    end

    // Build the flit for the winning channel; AW/AR are single-flit packets.
    always_comb begin
        sel_flit = '0;
        if (gnt_aw) begin
            sel_flit = {CH_AW, 1'b1, 1'b1, aw_tgtid, aw_payload};
        end else if (gnt_w) begin
            sel_flit = {CH_W, w_head, w_tail, w_tgtid, w_payload};
        end else if (gnt_ar) begin
            sel_flit = {CH_AR, 1'b1, 1'b1, ar_tgtid, ar_payload};
        end
    end

    // Output register: valid pulses one cycle, flit holds when idle.
    always_comb begin
        nvalid_d = any_gnt;
        flit_d   = any_gnt ? sel_flit : flit_q;
    end

    // All state registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OPEN;
            ptr_q    <= CH_AW;
            cred_q   <= CRED_MAX;
            err_q    <= 1'b0;
            nvalid_q <= 1'b0;
            flit_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cred_q   <= cred_d;
            err_q    <= err_d;
            nvalid_q <= nvalid_d;
            flit_q   <= flit_d;
        end
    end

    assign noc_valid  = nvalid_q;
    assign noc_flit   = flit_q;
    assign credit_cnt = cred_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_rn_inject_arb.sv
// tb_rn_inject_arb: directed self-checking bench for rn_inject_arb.
// Order test expectations follow RN_INJ_AR_PRIO_EN when it is defined.
module tb_rn_inject_arb;

    localparam int PW = 82;
    localparam int TW = 2;
    localparam int FW = PW + TW + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          aw_valid, aw_ready;
    logic [PW-1:0] aw_payload;
    logic [TW-1:0] aw_tgtid;
    logic          w_valid, w_ready, w_head, w_tail;
    logic [PW-1:0] w_payload;
    logic [TW-1:0] w_tgtid;
    logic          ar_valid, ar_ready;
    logic [PW-1:0] ar_payload;
    logic [TW-1:0] ar_tgtid;
    logic          noc_valid;
    logic [FW-1:0] noc_flit;
    logic          credit_in;
    logic [3:0]    credit_cnt;
    logic          credit_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rn_inject_arb #(.PAYLOAD_W(PW), .TGT_W(TW), .CREDITS(4)) dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .aw_payload(aw_payload), .aw_tgtid(aw_tgtid),
        .w_valid(w_valid), .w_ready(w_ready),
        .w_head(w_head), .w_tail(w_tail),
        .w_payload(w_payload), .w_tgtid(w_tgtid),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .ar_payload(ar_payload), .ar_tgtid(ar_tgtid),
        .noc_valid(noc_valid), .noc_flit(noc_flit),
        .credit_in(credit_in), .credit_cnt(credit_cnt),
        .credit_err(credit_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        ar_valid  = 1'b0;
        w_head    = 1'b0;
        w_tail    = 1'b0;
        credit_in = 1'b0;
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] ch, input logic h,
                                         input logic t, input logic [TW-1:0] tg,
                                         input logic [PW-1:0] p);
        return {ch, h, t, tg, p};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        cyc(); cyc();
        total++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
            bad++; $display("FAIL reset_ready got %b want 000", {aw_ready, w_ready, ar_ready});
        end
        total++;
        if (noc_valid !== 1'b0 || noc_flit !== '0) begin
            bad++; $display("FAIL reset_out got v=%b f=%h want v=0 f=0", noc_valid, noc_flit);
        end
        total++;
        if (credit_cnt !== 4'd4 || credit_err !== 1'b0) begin
            bad++; $display("FAIL reset_cred got %0d/%b want 4/0", credit_cnt, credit_err);
        end
        rst = 1'b0;
        idle();
        cyc();
    endtask

    task automatic test_rr();
        logic [FW-1:0] ef [3];
        logic [2:0]    er [3];
        aw_payload = 82'h0AA_1111; aw_tgtid = 2'd1;
        w_payload  = 82'h0BB_2222; w_tgtid  = 2'd2;
        ar_payload = 82'h0CC_3333; ar_tgtid = 2'd3;
        ef[0] = mk(2'd0, 1'b1, 1'b1, aw_tgtid, aw_payload);
        ef[1] = mk(2'd1, 1'b1, 1'b1, w_tgtid, w_payload);
        ef[2] = mk(2'd2, 1'b1, 1'b1, ar_tgtid, ar_payload);
        er[0] = 3'b100; er[1] = 3'b010; er[2] = 3'b001;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        w_head = 1'b1; w_tail = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({aw_ready, w_ready, ar_ready} !== er[i]) begin
                bad++; $display("FAIL rr_ready[%0d] got %b want %b", i, {aw_ready, w_ready, ar_ready}, er[i]);
            end
            cyc();
            total++;
            if (noc_valid !== 1'b1 || noc_flit !== ef[i]) begin
                bad++; $display("FAIL rr_flit[%0d] got v=%b f=%h want v=1 f=%h", i, noc_valid, noc_flit, ef[i]);
            end
            total++;
            if (credit_cnt !== 4'(3 - i)) begin
                bad++; $display("FAIL rr_cred[%0d] got %0d want %0d", i, credit_cnt, 3 - i);
            end
        end
        idle();
        cyc();
        total++;
        if (noc_valid !== 1'b0 || noc_flit !== ef[2]) begin
            bad++; $display("FAIL rr_hold got v=%b f=%h want v=0 f=%h", noc_valid, noc_flit, ef[2]);
        end
        credit_in = 1'b1;
        cyc(); cyc(); cyc();
        credit_in = 1'b0;
        total++;
        if (credit_cnt !== 4'd4 || credit_err !== 1'b0) begin
            bad++; $display("FAIL rr_refill got %0d/%b want 4/0", credit_cnt, credit_err);
        end
    endtask

    task automatic test_w_burst();
        logic h, t;
        credit_in = 1'b1;
        aw_valid = 1'b1;
        #1;
        total++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b100) begin
            bad++; $display("FAIL wb_pre got %b want 100", {aw_ready, w_ready, ar_ready});
        end
        cyc();
        w_valid = 1'b1; ar_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            h = (i == 0); t = (i == 3);
            w_head = h; w_tail = t;
            w_payload = 82'h500 + 82'(i);
            #1;
            total++;
            if ({aw_ready, w_ready, ar_ready} !== 3'b010) begin
                bad++; $display("FAIL wb_ready[%0d] got %b want 010", i, {aw_ready, w_ready, ar_ready});
            end
            cyc();
            total++;
            if (noc_flit !== mk(2'd1, h, t, w_tgtid, 82'h500 + 82'(i)) || credit_cnt !== 4'd4) begin
                bad++; $display("FAIL wb_flit[%0d] got f=%h c=%0d want chan1 c=4", i, noc_flit, credit_cnt);
            end
        end
        w_head = 1'b1; w_tail = 1'b1;
        #1;
        total++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b001) begin
            bad++; $display("FAIL wb_after_ar got %b want 001", {aw_ready, w_ready, ar_ready});
        end
        cyc();
        #1;
        total++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b100) begin
            bad++; $display("FAIL wb_after_aw got %b want 100", {aw_ready, w_ready, ar_ready});
        end
        cyc();
        idle();
        total++;
        if (noc_flit !== mk(2'd0, 1'b1, 1'b1, aw_tgtid, aw_payload) || credit_err !== 1'b0) begin
            bad++; $display("FAIL wb_end got f=%h e=%b want aw flit e=0", noc_flit, credit_err);
        end
    endtask

    task automatic test_credit_stall();
        aw_valid = 1'b1; ar_valid = 1'b1; w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_head = (i == 0); w_tail = 1'b0;
            #1;
            total++;
            if ({aw_ready, w_ready, ar_ready} !== 3'b010) begin
                bad++; $display("FAIL cs_ready[%0d] got %b want 010", i, {aw_ready, w_ready, ar_ready});
            end
            cyc();
            total++;
            if (credit_cnt !== 4'(3 - i)) begin
                bad++; $display("FAIL cs_cred[%0d] got %0d want %0d", i, credit_cnt, 3 - i);
            end
        end
        w_head = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
                bad++; $display("FAIL cs_stall[%0d] got %b want 000", i, {aw_ready, w_ready, ar_ready});
            end
            cyc();
            total++;
            if (noc_valid !== 1'b0 || credit_cnt !== 4'd0) begin
                bad++; $display("FAIL cs_idle[%0d] got v=%b c=%0d want 0/0", i, noc_valid, credit_cnt);
            end
        end
        credit_in = 1'b1;
        cyc();
        credit_in = 1'b0;
        #1;
        total++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b010 || credit_cnt !== 4'd1) begin
            bad++; $display("FAIL cs_one got r=%b c=%0d want 010/1", {aw_ready, w_ready, ar_ready}, credit_cnt);
        end
        cyc();
        total++;
        if (noc_flit !== mk(2'd1, 1'b0, 1'b0, w_tgtid, w_payload) || credit_cnt !== 4'd0) begin
            bad++; $display("FAIL cs_mid got f=%h c=%0d want mid W c=0", noc_flit, credit_cnt);
        end
        #1;
        total++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
            bad++; $display("FAIL cs_restall got %b want 000", {aw_ready, w_ready, ar_ready});
        end
        credit_in = 1'b1;
        cyc();
        credit_in = 1'b0;
        w_tail = 1'b1;
        cyc();
        total++;
        if (noc_flit !== mk(2'd1, 1'b0, 1'b1, w_tgtid, w_payload)) begin
            bad++; $display("FAIL cs_tail got %h want W tail", noc_flit);
        end
        idle();
        credit_in = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        credit_in = 1'b0;
    endtask

    task automatic test_credit_merge();
        ar_valid = 1'b1;
        cyc(); cyc();
        total++;
        if (credit_cnt !== 4'd2) begin
            bad++; $display("FAIL cm_drain got %0d want 2", credit_cnt);
        end
        credit_in = 1'b1;
        cyc();
        total++;
        if (credit_cnt !== 4'd2 || noc_valid !== 1'b1) begin
            bad++; $display("FAIL cm_same got c=%0d v=%b want 2/1", credit_cnt, noc_valid);
        end
        ar_valid = 1'b0;
        cyc(); cyc();
        total++;
        if (credit_cnt !== 4'd4 || credit_err !== 1'b0) begin
            bad++; $display("FAIL cm_full got %0d/%b want 4/0", credit_cnt, credit_err);
        end
        cyc();
        credit_in = 1'b0;
        total++;
        if (credit_cnt !== 4'd4 || credit_err !== 1'b1) begin
            bad++; $display("FAIL cm_ovf got %0d/%b want 4/1", credit_cnt, credit_err);
        end
        cyc(); cyc();
        total++;
        if (credit_err !== 1'b1) begin
            bad++; $display("FAIL cm_sticky got %b want 1", credit_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++;
        if (credit_err !== 1'b0 || credit_cnt !== 4'd4) begin
            bad++; $display("FAIL rb_clr got e=%b c=%0d want 0/4", credit_err, credit_cnt);
        end
        w_valid = 1'b1; w_head = 1'b1; w_tail = 1'b0;
        cyc();
        w_head = 1'b0;
        cyc();
        total++;
        if (credit_cnt !== 4'd2 || noc_valid !== 1'b1) begin
            bad++; $display("FAIL rb_two got c=%0d v=%b want 2/1", credit_cnt, noc_valid);
        end
        rst = 1'b1;
        ar_valid = 1'b1;
        #1;
        total++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
            bad++; $display("FAIL rb_rst_ready got %b want 000", {aw_ready, w_ready, ar_ready});
        end
        cyc();
        rst = 1'b0;
        w_valid = 1'b0;
        total++;
        if (credit_cnt !== 4'd4 || noc_valid !== 1'b0 || noc_flit !== '0) begin
            bad++; $display("FAIL rb_state got c=%0d v=%b f=%h want 4/0/0", credit_cnt, noc_valid, noc_flit);
        end
        #1;
        total++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b001) begin
            bad++; $display("FAIL rb_ar got %b want 001", {aw_ready, w_ready, ar_ready});
        end
        cyc();
        idle();
        total++;
        if (noc_flit !== mk(2'd2, 1'b1, 1'b1, ar_tgtid, ar_payload) || credit_cnt !== 4'd3) begin
            bad++; $display("FAIL rb_ar_flit got f=%h c=%0d want AR c=3", noc_flit, credit_cnt);
        end
    endtask

    task automatic test_order();
        logic [2:0] er [4];
`ifdef RN_INJ_AR_PRIO_EN
        er[0] = 3'b001; er[1] = 3'b001; er[2] = 3'b001; er[3] = 3'b001;
`else
        er[0] = 3'b100; er[1] = 3'b010; er[2] = 3'b001; er[3] = 3'b100;
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        w_head = 1'b1; w_tail = 1'b1;
        credit_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({aw_ready, w_ready, ar_ready} !== er[i]) begin
                bad++; $display("FAIL ord[%0d] got %b want %b", i, {aw_ready, w_ready, ar_ready}, er[i]);
            end
            cyc();
        end
        idle();
        total++;
        if (credit_cnt !== 4'd4 || credit_err !== 1'b0) begin
            bad++; $display("FAIL ord_cred got %0d/%b want 4/0", credit_cnt, credit_err);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        aw_payload = '0; aw_tgtid = '0;
        w_payload  = '0; w_tgtid  = '0;
        ar_payload = '0; ar_tgtid = '0;
        test_reset();
        test_rr();
        test_w_burst();
        test_credit_stall();
        test_credit_merge();
        test_reset_mid_burst();
        test_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rn_inject_arb.md
Name: rn_inject_arb

Overview:
Credit-based injection arbiter for a request node (RN). It merges the RN wrapper's AW, W and AR flit streams onto a single NoC injection link. AW and AR requests are single-flit packets; W bursts are multi-flit packets delimited by head/tail. The block does round-robin arbitration, keeps a W burst contiguous, and tracks downstream buffer credits.

Parameters:
PAYLOAD_W, 82, flit payload width for all three channels
TGT_W, 2, target node ID width
CREDITS, 4, downstream input-buffer depth in flits; credit counter reset value (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
aw_valid  in  1  AW flit valid
aw_ready  out  1  AW flit accepted this cycle
aw_payload  in  PAYLOAD_W  AW flit payload
aw_tgtid  in  TGT_W  AW target node
w_valid  in  1  W flit valid
w_ready  out  1  W flit accepted this cycle
w_head  in  1  first flit of W burst
w_tail  in  1  last flit of W burst
w_payload  in  PAYLOAD_W  W flit payload
w_tgtid  in  TGT_W  W target node
ar_valid  in  1  AR flit valid
ar_ready  out  1  AR flit accepted this cycle
ar_payload  in  PAYLOAD_W  AR flit payload
ar_tgtid  in  TGT_W  AR target node
noc_valid  out  1  registered injection flit valid
noc_flit  out  PAYLOAD_W+TGT_W+4  {chan[1:0], head, tail, tgtid, payload}; chan 0=AW, 1=W, 2=AR
credit_in  in  1  one credit returned by downstream this cycle
credit_cnt  out  4  current credit count
credit_err  out  1  sticky: credit returned while counter already at CREDITS

Behaviour:
- Reset values: noc_valid=0, noc_flit=0, credit_cnt=CREDITS, credit_err=0, lock=0, RR pointer=AW. All *_ready=0 during rst.
- Eligibility: a grant is possible only when credit_cnt>0.
- Ready signals are combinational from the grant. At most one *_ready is high per cycle. Handshake = valid & ready. Ready never asserts without the matching valid.
- Round robin, unlocked: priority order starts at the pointer and runs AW→W→AR→AW. The first valid channel wins. After a grant, the pointer moves to the channel after the winner.
- W lock: a granted W flit with w_head=1 and w_tail=0 sets lock=1. While locked, only W can be granted (only when w_valid and credit>0). The AW/AR pointer is frozen. A granted W flit with w_tail=1 clears lock and moves the pointer to AR. A head+tail W flit does not lock.
- AW/AR flits are emitted with head=tail=1 regardless of input. W flits carry w_head/w_tail unchanged.
- Latency: a flit handshaked in cycle N appears on noc_valid/noc_flit in cycle N+1, for exactly one cycle. noc_flit holds its last value when noc_valid=0.
- Credits: a grant decrements credit_cnt; credit_in increments it. If both occur in the same cycle, the count is unchanged.
- Credits at 0: no grant. The lock persists and the W stream stalls mid-burst.
- Credit overflow: credit_in at CREDITS with no grant saturates the count at CREDITS and sets credit_err until rst.
- Reset mid-burst: lock, pointer, credits and the output register return to reset values. The upstream sender must restart the burst with a head flit.
- No flit is dropped or duplicated. The valid/payload of an unaccepted channel may change freely; no stability requirement applies inside this block.

Optional Feature:
RN_INJ_AR_PRIO_EN:
- Defined: when unlocked, AR has strict priority over AW and W (read-latency optimisation). The RR pointer arbitrates only between AW and W. The lock still overrides AR mid-burst.
- Undefined: pure three-way round robin as above.

Test Plan:
- Reset, then all three channels valid with single flits and CREDITS=4, credit_in=0 → grants AW, W, AR in successive cycles. noc_flit chan=0,1,2 one cycle later. credit_cnt 4→1.
- W burst of 4 flits (head on 1st, tail on 4th) with AW and AR continuously valid and credits refilled each cycle → 4 consecutive W grants. AR is granted next, then AW.
- Credits drained to 0 mid-W-burst → all ready=0 and lock held. credit_in pulse → exactly one W flit granted, then stall again.
- Grant and credit_in in the same cycle at credit_cnt=2 → credit_cnt stays 2. credit_in at 4 with no grant → credit_cnt=4, credit_err=1 and sticky.
- rst asserted while lock=1 after 2 of 4 W flits → next cycle credit_cnt=4, noc_valid=0. A subsequent AR flit is granted immediately.
- With RN_INJ_AR_PRIO_EN, AW/W/AR all valid for 4 cycles, unlocked, ample credits → AR granted every cycle. Undefined → grant order AW, W, AR, AW.
